clt_gauss: RTL and testbench

CLT_GAUSS -- requirements
Module: clt_gauss

---
 rtl/clt_gauss.sv | 79 +++++++
 tb/tb_clt_gauss.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/clt_gauss.sv
// rtl/clt_gauss.sv - CLT Gaussian approximator: sums 2^LOG2_N words (two 16-bit halves each).
// Optional build macro CLT_MEAN_REMOVE_EN: output is the signed sum minus 2^(SUM_W-1).
module clt_gauss #(
  parameter  int LOG2_N = 3,
  localparam int SUM_W  = 17 + LOG2_N
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SUM_W-1:0] gauss_out,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {ACC, STALL} state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [SUM_W-1:0]   out_q, out_d;
  logic [LOG2_N-1:0]  cnt_q, cnt_d;
  logic               ov_q, ov_d;
  logic [SUM_W-1:0]   sum_w;
  logic               accept;
  logic               last_word;

  assign in_ready  = (state_q == ACC) && !reset;
  assign accept    = in_valid && in_ready;
  assign last_word = &cnt_q;
  assign sum_w     = acc_q + SUM_W'(data[31:16]) + SUM_W'(data[15:0]);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    out_d = out_q;
    ov_d  = ov_q;
    if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end
    if (accept) begin
      if (last_word) begin
        acc_d = '0;
        cnt_d = '0;
        ov_d  = 1'b1;
`ifdef CLT_MEAN_REMOVE_EN
        out_d = {~sum_w[SUM_W-1], sum_w[SUM_W-2:0]};
`else
        out_d = sum_w;
`endif
      end else begin
        acc_d = sum_w;
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Stall as soon as the final word would find the output register still occupied.
    state_d = ((&cnt_d) && ov_d) ? STALL : ACC;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

  assign gauss_out = out_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_clt_gauss.sv
// tb/tb_clt_gauss.sv - randomized, model-checked bench for clt_gauss (LOG2_N=3).
module tb_clt_gauss;

  localparam int LOG2_N = 3;
  localparam int N      = 1 << LOG2_N;
  localparam int SUM_W  = 17 + LOG2_N;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [SUM_W-1:0] gauss_out;
  logic             out_valid;
  logic             out_ready = 1'b1;

  clt_gauss #(.LOG2_N(LOG2_N)) dut (
    .clk(clk), .reset(reset), .data(data), .in_valid(in_valid), .in_ready(in_ready),
    .gauss_out(gauss_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: words collected so far, undelivered samples.
  int               m_partial = 0;
  int               m_sum = 0;
  logic [SUM_W-1:0] m_q[$];

  logic [SUM_W-1:0] last_dlv = '0;
  int               n_dlv = 0;
  int               n_acc = 0;
  int               n_block = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [SUM_W-1:0] to_out(input int s);
    int v;
`ifdef CLT_MEAN_REMOVE_EN
    v = s - (1 << (SUM_W - 1));
`else
    v = s;
`endif
    return SUM_W'(v & ((1 << SUM_W) - 1));
  endfunction

  function automatic logic [SUM_W-1:0] lit(input logic [SUM_W-1:0] raw, input logic [SUM_W-1:0] centred);
`ifdef CLT_MEAN_REMOVE_EN
    return centred;
`else
    return raw;
`endif
  endfunction

  always @(negedge clk) begin
    logic exp_ir;
    exp_ir = !reset && !(m_partial == N - 1 && m_q.size() > 0);
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() > 0});
    if (m_q.size() > 0) chk("gauss_out", 32'(gauss_out), 32'(m_q[0]));
    if (out_valid && out_ready) begin
      last_dlv = gauss_out;
      n_dlv++;
    end
    if (in_valid && in_ready) n_acc++;
    if (in_valid && !in_ready) n_block++;
    // Advance the model to the state after the coming rising edge.
    if (reset) begin
      m_partial = 0;
      m_sum = 0;
      m_q.delete();
    end else begin
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (in_valid && exp_ir) begin
        m_sum += int'(data[31:16]) + int'(data[15:0]);
        m_partial++;
        if (m_partial == N) begin
          m_q.push_back(to_out(m_sum));
          m_sum = 0;
          m_partial = 0;
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic r);
    in_valid = v;
    data = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    repeat (3) cyc(1'b1, 32'hFFFF_FFFF, 1'b1);
    reset = 1'b0;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_gauss_out", 32'(gauss_out), 32'd0);

    // All-ones words: maximum sum.
    repeat (N) cyc(1'b1, 32'hFFFF_FFFF, 1'b1);
    chk("max_latency_valid", {31'b0, out_valid}, 32'd1);
    repeat (3) cyc(1'b0, 32'h0, 1'b1);
    chk("max_sum", 32'(last_dlv), 32'(lit(20'hFFFF0, 20'h7FFF0)));

    repeat (N) cyc(1'b1, 32'h0001_0002, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 1'b1);
    chk("small_sum", 32'(last_dlv), 32'(lit(20'h00018, 20'h80018)));

    // Continuous stream: one output per N cycles, never blocked.
    n_dlv = 0;
    n_block = 0;
    repeat (64) cyc(1'b1, $urandom, 1'b1);
    repeat (2) cyc(1'b0, 32'h0, 1'b1);
    chk("stream_outputs", 32'(n_dlv), 32'd8);
    chk("stream_blocked", 32'(n_block), 32'd0);

    // Downstream stall: 7 more words fit, then in_ready drops.
    repeat (N) cyc(1'b1, $urandom, 1'b1);
    n_acc = 0;
    repeat (20) cyc(1'b1, $urandom, 1'b0);
    chk("stall_accepts", 32'(n_acc), 32'd7);
    repeat (20) cyc(1'b1, $urandom, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 1'b1);

    // Reset mid-accumulation.
    repeat (5) cyc(1'b1, $urandom, 1'b1);
    reset = 1'b1;
    repeat (2) cyc(1'b1, 32'hFFFF_FFFF, 1'b1);
    reset = 1'b0;
    repeat (N) cyc(1'b1, 32'hFFFF_FFFF, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 1'b1);
    chk("post_reset_sum", 32'(last_dlv), 32'(lit(20'hFFFF0, 20'h7FFF0)));

    // Alternating in_valid.
    for (int i = 0; i < 2 * N; i++) cyc(i[0] == 1'b0, 32'h1234_5678, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 1'b1);
    chk("toggle_sum", 32'(last_dlv), 32'(lit(20'h34560, 20'hB4560)));

    // Random traffic against the model.
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
    repeat (4) cyc(1'b0, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
